// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared constants and fetch FSM state type for the shader fetch unit
package gpu_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_WIDTH = OPCODE_MSB - OPCODE_LSB + 1;
    localparam logic [OPCODE_WIDTH-1:0] END_OPCODE = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/shader_fetch_fifo.sv
// rtl/shader_fetch_fifo.sv - two-entry instruction buffer with synchronous flush
module shader_fetch_fifo #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] slot [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            slot[wr_ptr] <= push_data;
        end
    end

    assign pop_data = slot[rd_ptr];
    assign empty    = (count == 2'd0);
    assign full     = (count == 2'd2);

endmodule

// File: rtl/shader_fetch.sv
// rtl/shader_fetch.sv - shader instruction fetch FSM and pc; SHADER_FETCH_PERF_EN enables the accepted-instruction counter
module shader_fetch
    import gpu_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int INSTR_DEPTH = 256,
    localparam int AW = $clog2(INSTR_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [AW-1:0]          i_start_pc,
    input  logic                   i_halt,
    input  logic                   i_redirect,
    input  logic [AW-1:0]          i_redirect_pc,
    output logic [AW-1:0]          o_imem_addr,
    input  logic [INSTR_WIDTH-1:0] i_imem_instr,
    output logic                   o_instr_valid,
    input  logic                   i_instr_ready,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [AW-1:0]          o_instr_pc,
    output logic                   o_busy,
    output logic [31:0]            o_fetch_count
);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [AW-1:0]   pc;
    logic [AW-1:0]   pc_next;
    logic [AW-1:0]   pc_inc;
    logic            push;
    logic            flush;
    logic            pop;
    logic            empty;
    logic            full;
    logic            is_end;

    assign pc_inc = (pc == AW'(INSTR_DEPTH - 1)) ? '0 : pc + 1'b1;
    assign is_end = (i_imem_instr[OPCODE_MSB:OPCODE_LSB] == END_OPCODE);

    // Valid is masked during reset so no handshake can complete in that cycle.
    assign o_instr_valid = !empty && !rst;
    assign pop           = o_instr_valid && i_instr_ready;
    assign o_imem_addr   = pc;
    assign o_busy        = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        flush      = 1'b0;
        if (i_halt) begin
            flush      = 1'b1;
            state_next = ST_IDLE;
        end else if (i_redirect && state != ST_IDLE) begin
            flush      = 1'b1;
            pc_next    = i_redirect_pc;
            state_next = ST_FETCH;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        pc_next    = i_start_pc;
                        state_next = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!full || pop) begin
                        push    = 1'b1;
                        pc_next = pc_inc;
                        if (is_end) begin
                            state_next = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // No pushes here, so a pop from a non-full buffer empties it.
                    if (pop && !full) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    shader_fetch_fifo #(
        .WIDTH(INSTR_WIDTH + AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push),
        .push_data({i_imem_instr, pc}),
        .pop      (pop),
        .pop_data ({o_instr, o_instr_pc}),
        .empty    (empty),
        .full     (full)
    );

`ifdef SHADER_FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic        start_take;

    assign start_take = (state == ST_IDLE) && i_start && !i_halt;

    always_ff @(posedge clk) begin
        if (rst || start_take) begin
            fetch_count <= 32'd0;
        end else if (pop) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign o_fetch_count = fetch_count;
`else
    assign o_fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_shader_fetch.sv
// tb/tb_shader_fetch.sv - self-checking bench for shader_fetch with a queue-based program model
module tb_shader_fetch;

    localparam int W = 32;
    localparam int AW = 8;
    localparam logic [5:0] END_OP = 6'h3F;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [AW-1:0] i_start_pc;
    logic          i_halt;
    logic          i_redirect;
    logic [AW-1:0] i_redirect_pc;
    logic [AW-1:0] o_imem_addr;
    logic [W-1:0]  i_imem_instr;
    logic          o_instr_valid;
    logic          i_instr_ready;
    logic [W-1:0]  o_instr;
    logic [AW-1:0] o_instr_pc;
    logic          o_busy;
    logic [31:0]   o_fetch_count;

    logic [W-1:0]  mem [256];
    int            checks = 0;
    int            failures = 0;
    logic [W-1:0]  exp_w [$];
    logic [AW-1:0] exp_a [$];

    assign i_imem_instr = mem[o_imem_addr];

    always #5 clk = ~clk;

    shader_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_start_pc   (i_start_pc),
        .i_halt       (i_halt),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_imem_addr  (o_imem_addr),
        .i_imem_instr (i_imem_instr),
        .o_instr_valid(o_instr_valid),
        .i_instr_ready(i_instr_ready),
        .o_instr      (o_instr),
        .o_instr_pc   (o_instr_pc),
        .o_busy       (o_busy),
        .o_fetch_count(o_fetch_count)
    );

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        w = $urandom;
        w[31:26] = 6'($urandom_range(0, 62));
        return w;
    endfunction

    function automatic logic [W-1:0] end_word();
        logic [W-1:0] w;
        w = $urandom;
        w[31:26] = END_OP;
        return w;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected delivery order: walk memory from start, wrapping, through the first END word.
    task automatic build_expect(input logic [AW-1:0] start);
        logic [AW-1:0] a;
        exp_w.delete();
        exp_a.delete();
        a = start;
        for (int i = 0; i < 256; i++) begin
            exp_w.push_back(mem[a]);
            exp_a.push_back(a);
            if (mem[a][31:26] == END_OP) break;
            a = a + 8'd1;
        end
    endtask

    task automatic expect_out(input string name, input logic [W-1:0] w, input logic [AW-1:0] a);
        checks++;
        if (o_instr_valid !== 1'b1 || o_instr !== w || o_instr_pc !== a) begin
            failures++;
            $display("FAIL %s: valid=%b instr=%h pc=%0d required valid=1 instr=%h pc=%0d",
                     name, o_instr_valid, o_instr, o_instr_pc, w, a);
        end
    endtask

    task automatic expect_idle(input string name);
        checks++;
        if (o_busy !== 1'b0 || o_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s: busy=%b valid=%b required busy=0 valid=0", name, o_busy, o_instr_valid);
        end
    endtask

    task automatic expect_count(input string name, input logic [31:0] n);
        logic [31:0] req;
`ifdef SHADER_FETCH_PERF_EN
        req = n;
`else
        req = 32'd0;
`endif
        checks++;
        if (o_fetch_count !== req) begin
            failures++;
            $display("FAIL %s: fetch_count=%0d required %0d", name, o_fetch_count, req);
        end
    endtask

    // Runs a program to completion with random ready, scoring every handshake.
    task automatic run_random(input string name, input logic [AW-1:0] start);
        int n_acc;
        int budget;
        build_expect(start);
        n_acc = 0;
        i_start = 1'b1;
        i_start_pc = start;
        i_instr_ready = 1'b0;
        cycle();
        i_start = 1'b0;
        budget = 0;
        while (o_busy === 1'b1 && budget < 400) begin
            i_instr_ready = 1'($urandom_range(0, 1));
            #1;
            if (o_instr_valid && i_instr_ready) begin
                if (exp_w.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s: extra word pc=%0d required none", name, o_instr_pc);
                end else begin
                    expect_out(name, exp_w.pop_front(), exp_a.pop_front());
                    n_acc++;
                end
            end
            cycle();
            budget++;
        end
        checks++;
        if (budget >= 400 || exp_w.size() != 0) begin
            failures++;
            $display("FAIL %s_done: cycles=%0d left=%0d required left=0", name, budget, exp_w.size());
        end
        expect_count({name, "_cnt"}, 32'(n_acc));
        i_instr_ready = 1'b0;
    endtask

    task automatic load_abe(input logic [AW-1:0] base, output logic [W-1:0] a, output logic [W-1:0] b);
        a = rand_word();
        b = rand_word();
        mem[base] = a;
        mem[base + 8'd1] = b;
        mem[base + 8'd2] = end_word();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        expect_idle("reset_idle");
        checks++;
        if (o_imem_addr !== 8'd0 || o_fetch_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_vals: addr=%0d count=%0d required 0 0", o_imem_addr, o_fetch_count);
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_basic();
        logic [W-1:0] a, b;
        load_abe(8'd4, a, b);
        i_instr_ready = 1'b1;
        i_start = 1'b1;
        i_start_pc = 8'd4;
        cycle();
        i_start = 1'b0;
        checks++;
        if (o_instr_valid !== 1'b0 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_n1: valid=%b busy=%b required 0 1", o_instr_valid, o_busy);
        end
        cycle();
        expect_out("basic_a", a, 8'd4);
        cycle();
        expect_out("basic_b", b, 8'd5);
        cycle();
        expect_out("basic_end", mem[6], 8'd6);
        cycle();
        expect_idle("basic_idle");
        expect_count("basic_cnt", 32'd3);
        i_instr_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [W-1:0] a, b;
        load_abe(8'd4, a, b);
        i_instr_ready = 1'b0;
        i_start = 1'b1;
        i_start_pc = 8'd4;
        cycle();
        i_start = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            expect_out("stall_hold", a, 8'd4);
            cycle();
        end
        checks++;
        if (o_imem_addr !== 8'd6) begin
            failures++;
            $display("FAIL stall_pc: pc=%0d required 6", o_imem_addr);
        end
        i_instr_ready = 1'b1;
        #1;
        expect_out("stall_a", a, 8'd4);
        cycle();
        expect_out("stall_b", b, 8'd5);
        cycle();
        expect_out("stall_end", mem[6], 8'd6);
        cycle();
        expect_idle("stall_idle");
        expect_count("stall_cnt", 32'd3);
        i_instr_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [W-1:0] a;
        a = rand_word();
        mem[255] = a;
        mem[0] = end_word();
        i_instr_ready = 1'b1;
        i_start = 1'b1;
        i_start_pc = 8'd255;
        cycle();
        i_start = 1'b0;
        cycle();
        expect_out("wrap_a", a, 8'd255);
        cycle();
        expect_out("wrap_end", mem[0], 8'd0);
        cycle();
        expect_idle("wrap_idle");
        i_instr_ready = 1'b0;
        mem[0] = rand_word();
    endtask

    task automatic test_redirect();
        for (int i = 10; i < 30; i++) mem[i] = rand_word();
        mem[22] = end_word();
        i_instr_ready = 1'b0;
        i_start = 1'b1;
        i_start_pc = 8'd10;
        cycle();
        i_start = 1'b0;
        cycle();
        cycle();
        i_redirect = 1'b1;
        i_redirect_pc = 8'd20;
        i_instr_ready = 1'b1;
        cycle();
        i_redirect = 1'b0;
        checks++;
        if (o_instr_valid !== 1'b0 || o_imem_addr !== 8'd20) begin
            failures++;
            $display("FAIL redir_flush: valid=%b pc=%0d required 0 20", o_instr_valid, o_imem_addr);
        end
        cycle();
        expect_out("redir_20", mem[20], 8'd20);
        cycle();
        expect_out("redir_21", mem[21], 8'd21);
        cycle();
        expect_out("redir_22", mem[22], 8'd22);
        cycle();
        expect_idle("redir_idle");
        i_instr_ready = 1'b0;
        mem[22] = rand_word();
    endtask

    task automatic test_halt_redirect();
        logic [W-1:0] a, b;
        load_abe(8'd4, a, b);
        i_start = 1'b1;
        i_start_pc = 8'd40;
        cycle();
        i_start = 1'b0;
        cycle();
        cycle();
        i_halt = 1'b1;
        i_redirect = 1'b1;
        i_redirect_pc = 8'd50;
        cycle();
        i_halt = 1'b0;
        i_redirect = 1'b0;
        expect_idle("halt_idle");
        cycle();
        expect_idle("halt_stays");
        i_instr_ready = 1'b1;
        i_start = 1'b1;
        i_start_pc = 8'd4;
        cycle();
        i_start = 1'b0;
        cycle();
        expect_out("halt_restart", a, 8'd4);
        cycle();
        expect_out("halt_restart_b", b, 8'd5);
        cycle();
        cycle();
        expect_idle("halt_restart_idle");
        i_instr_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        i_instr_ready = 1'b0;
        i_start = 1'b1;
        i_start_pc = 8'd60;
        cycle();
        i_start = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        i_instr_ready = 1'b1;
        #1;
        checks++;
        if (o_instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_nohs: valid=%b required 0", o_instr_valid);
        end
        cycle();
        rst = 1'b0;
        expect_idle("rstmid_idle");
        checks++;
        if (o_imem_addr !== 8'd0) begin
            failures++;
            $display("FAIL rstmid_pc: pc=%0d required 0", o_imem_addr);
        end
        i_instr_ready = 1'b0;
    endtask

    task automatic test_random_programs();
        logic [AW-1:0] s;
        int len;
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = rand_word();
            s = 8'($urandom);
            len = $urandom_range(1, 9);
            mem[8'(s + 8'(len - 1))] = end_word();
            run_random("rand", s);
            cycle();
        end
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_start_pc = '0;
        i_halt = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = '0;
        i_instr_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = rand_word();
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_redirect();
        test_halt_redirect();
        test_reset_mid();
        test_random_programs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
